// File: rtl/switch_allocator_if.sv
// Allocator-side bundle: head-flit requests and credit returns in, grants and crossbar selects out.
interface switch_allocator_if #(
  parameter int unsigned PORT_NUM  = 5,
  parameter int unsigned SEL_WIDTH = 3
);
  logic [PORT_NUM-1:0]  reqValid;
  logic [SEL_WIDTH-1:0] reqPort [PORT_NUM];
  logic [PORT_NUM-1:0]  creditIn;
  logic [PORT_NUM-1:0]  reqGrant;
  logic [SEL_WIDTH-1:0] sel [PORT_NUM];
  logic [PORT_NUM-1:0]  outValid;
  logic [1:0]           errFlag;

  modport master (
    output reqValid, reqPort, creditIn,
    input  reqGrant, sel, outValid, errFlag
  );

  modport slave (
    input  reqValid, reqPort, creditIn,
    output reqGrant, sel, outValid, errFlag
  );
endinterface

// File: rtl/switch_allocator.sv
// Separable switch allocator: per-output round-robin arbitration gated by downstream credits.
module switch_allocator #(
  parameter int unsigned PORT_NUM     = 5,
  parameter int unsigned SEL_WIDTH    = 3,
  parameter int unsigned CREDIT_NUM   = 4,
  parameter int unsigned CREDIT_WIDTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  switch_allocator_if.slave bus
);

  localparam logic [SEL_WIDTH-1:0]    IdleSel = SEL_WIDTH'(PORT_NUM);
  localparam logic [SEL_WIDTH-1:0]    LastIdx = SEL_WIDTH'(PORT_NUM - 1);
  localparam logic [CREDIT_WIDTH-1:0] CredMax = CREDIT_WIDTH'(CREDIT_NUM);

  logic [SEL_WIDTH-1:0]    rr_ptr_q   [PORT_NUM];
  logic [SEL_WIDTH-1:0]    rr_ptr_d   [PORT_NUM];
  logic [CREDIT_WIDTH-1:0] cred_cnt_q [PORT_NUM];
  logic [CREDIT_WIDTH-1:0] cred_cnt_d [PORT_NUM];
  logic [1:0]              err_q, err_d;

  logic [PORT_NUM-1:0]     grant;
  logic [PORT_NUM-1:0]     valid;
  logic [SEL_WIDTH-1:0]    sel_w [PORT_NUM];

  // Each input names a single output, so per-output arbiters never collide on an input.
  always_comb begin
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
    grant = '0;
    valid = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < PORT_NUM; j++) begin
      sel_w[j] = IdleSel;
      found    = 1'b0;
      if (!reset && cred_cnt_q[j] != '0) begin
        for (int unsigned k = 0; k < PORT_NUM; k++) begin
          idx = SEL_WIDTH'((32'(rr_ptr_q[j]) + k) % PORT_NUM);
          if (!found && bus.reqValid[idx] && bus.reqPort[idx] == SEL_WIDTH'(j)) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            valid[j]   = 1'b1;
            sel_w[j]   = idx;
          end
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (bus.reqValid[i] && bus.reqPort[i] >= IdleSel) err_d[0] = 1'b1;
    end
    for (int unsigned j = 0; j < PORT_NUM; j++) begin
      rr_ptr_d[j]   = rr_ptr_q[j];
      cred_cnt_d[j] = cred_cnt_q[j];
      if (valid[j]) begin
        rr_ptr_d[j] = (sel_w[j] == LastIdx) ? '0 : sel_w[j] + SEL_WIDTH'(1);
      end
      if (bus.creditIn[j] && !valid[j]) begin
        // A return into an already-full counter is a downstream protocol error.
        if (cred_cnt_q[j] == CredMax) err_d[1] = 1'b1;
        else                          cred_cnt_d[j] = cred_cnt_q[j] + CREDIT_WIDTH'(1);
      end else if (!bus.creditIn[j] && valid[j]) begin
        cred_cnt_d[j] = cred_cnt_q[j] - CREDIT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
      for (int unsigned j = 0; j < PORT_NUM; j++) begin
        rr_ptr_q[j]   <= '0;
        cred_cnt_q[j] <= CredMax;
      end
    end else begin
      err_q <= err_d;
      for (int unsigned j = 0; j < PORT_NUM; j++) begin
        rr_ptr_q[j]   <= rr_ptr_d[j];
        cred_cnt_q[j] <= cred_cnt_d[j];
      end
    end
  end

  assign bus.reqGrant = grant;
  assign bus.outValid = valid;
  assign bus.errFlag  = err_q;

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_sel
    assign bus.sel[g] = sel_w[g];
  end

endmodule
